// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock-loss sequencer: pulses PLL RESETB, qualifies lock, then
// releases per-domain resets in a staggered order and watches for lock loss.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT     = 65536,
  parameter int unsigned STABLE_CYCLES    = 1024,
  parameter int unsigned LOSS_FILTER      = 4,
  parameter int unsigned NUM_DOMAINS      = 2,
  parameter int unsigned RELEASE_GAP      = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   locked,
  input  logic                   lock_lost_clr,
  output logic                   pll_resetb,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [7:0]             loss_count,
  output logic [7:0]             retry_count
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned REL_SPAN = (NUM_DOMAINS - 1) * RELEASE_GAP + 1;
  localparam int unsigned MAX_P    = max2(max2(max2(PLL_RESET_CYCLES, LOCK_TIMEOUT),
                                               max2(STABLE_CYCLES, LOSS_FILTER)),
                                          max2(max2(NUM_DOMAINS, RELEASE_GAP), REL_SPAN));
  localparam int unsigned CNT_W    = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int unsigned FLT_W    = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_SPAN - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOSS_FILTER - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [FLT_W-1:0]       flt_r;
  logic                   sync_meta_r;
  logic                   locked_sync_r;
  logic                   loss_evt_s;
  logic                   timeout_s;
  logic                   pll_resetb_nxt_s;
  logic [NUM_DOMAINS-1:0] domain_nxt_s;
  logic                   ready_nxt_s;
  logic                   lock_lost_nxt_s;
  logic [7:0]             loss_count_nxt_s;
  logic [7:0]             retry_count_nxt_s;

  // State register, lock synchronizer, shared cycle counter and loss filter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r       <= PLL_RST;
      cnt_r         <= '0;
      flt_r         <= '0;
      sync_meta_r   <= 1'b0;
      locked_sync_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      sync_meta_r   <= locked;
      locked_sync_r <= sync_meta_r;
      if (state_nxt_s != state_r) begin
        cnt_r <= '0;
      end else if (cnt_r != {CNT_W{1'b1}}) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      // Filter counts consecutive unlocked RUN cycles only.
      if ((state_r == RUN) && !locked_sync_r && !loss_evt_s) begin
        flt_r <= flt_r + FLT_W'(1);
      end else begin
        flt_r <= '0;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    loss_evt_s  = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      PLL_RST: begin
        if (cnt_r == RST_LAST) state_nxt_s = WAIT_LOCK;
        else                   state_nxt_s = PLL_RST;
      end
      WAIT_LOCK: begin
        if (locked_sync_r) begin
          state_nxt_s = STABILIZE;
        end else if (cnt_r == TMO_LAST) begin
          state_nxt_s = PLL_RST;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      STABILIZE: begin
        if (!locked_sync_r)        state_nxt_s = WAIT_LOCK;
        else if (cnt_r == STB_LAST) state_nxt_s = RELEASE;
        else                       state_nxt_s = STABILIZE;
      end
      RELEASE: begin
        if (!locked_sync_r)        state_nxt_s = WAIT_LOCK;
        else if (cnt_r == REL_LAST) state_nxt_s = RUN;
        else                       state_nxt_s = RELEASE;
      end
      RUN: begin
        if (!locked_sync_r && (flt_r == FLT_LAST)) begin
          state_nxt_s = PLL_RST;
          loss_evt_s  = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = PLL_RST;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    domain_nxt_s = domain_reset_n;
    case (state_r)
      RELEASE: begin
        if (!locked_sync_r) begin
          domain_nxt_s = '0;
        end else begin
          // Domain i is released on the edge ending RELEASE cycle i*RELEASE_GAP.
          for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
            if (cnt_r == CNT_W'(i * RELEASE_GAP)) domain_nxt_s[i] = 1'b1;
            else                                  domain_nxt_s[i] = domain_reset_n[i];
          end
        end
      end
      RUN: begin
        if (loss_evt_s) domain_nxt_s = '0;
        else            domain_nxt_s = domain_reset_n;
      end
      default: begin
        domain_nxt_s = '0;
      end
    endcase

    pll_resetb_nxt_s = (state_nxt_s != PLL_RST);
    ready_nxt_s      = (state_nxt_s == RUN);

    if (loss_evt_s)         lock_lost_nxt_s = 1'b1;
    else if (lock_lost_clr) lock_lost_nxt_s = 1'b0;
    else                    lock_lost_nxt_s = lock_lost;

    if (loss_evt_s && (loss_count != 8'hFF)) loss_count_nxt_s = loss_count + 8'd1;
    else                                     loss_count_nxt_s = loss_count;

    if (timeout_s && (retry_count != 8'hFF)) retry_count_nxt_s = retry_count + 8'd1;
    else                                     retry_count_nxt_s = retry_count;
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pll_resetb     <= 1'b0;
      domain_reset_n <= '0;
      ready          <= 1'b0;
      lock_lost      <= 1'b0;
      loss_count     <= 8'd0;
      retry_count    <= 8'd0;
    end else begin
      pll_resetb     <= pll_resetb_nxt_s;
      domain_reset_n <= domain_nxt_s;
      ready          <= ready_nxt_s;
      lock_lost      <= lock_lost_nxt_s;
      loss_count     <= loss_count_nxt_s;
      retry_count    <= retry_count_nxt_s;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: every output change must match the
// next queued expectation, both in value and in the cycle it appears.
module tb_pll_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       locked;
  logic       lock_lost_clr;
  logic       pll_resetb;
  logic [2:0] domain_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] loss_count;
  logic [7:0] retry_count;

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES(4),
    .LOCK_TIMEOUT    (32),
    .STABLE_CYCLES   (8),
    .LOSS_FILTER     (3),
    .NUM_DOMAINS     (3),
    .RELEASE_GAP     (2)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .locked        (locked),
    .lock_lost_clr (lock_lost_clr),
    .pll_resetb    (pll_resetb),
    .domain_reset_n(domain_reset_n),
    .ready         (ready),
    .lock_lost     (lock_lost),
    .loss_count    (loss_count),
    .retry_count   (retry_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int unsigned cyc;
    logic [21:0] vec;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        armed = 1'b0;
  logic [21:0] cur;
  logic [21:0] prev;
  logic [21:0] out_vec;

  assign out_vec = {pll_resetb, domain_reset_n, ready, lock_lost, loss_count, retry_count};

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [21:0] v(input logic pb, input logic [2:0] d, input logic r,
                                    input logic ll, input logic [7:0] lc, input logic [7:0] rc);
    return {pb, d, r, ll, lc, rc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int unsigned c, input logic [21:0] vv);
    exp_t e;
    e.cyc = c;
    e.vec = vv;
    q.push_back(e);
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic drained(input string name);
    check(name, q.size(), 32'd0);
    q.delete();
  endtask

  // Monitor: any output change pops and checks the next expectation.
  always @(negedge clock) begin
    cur = out_vec;
    if (armed && (cur !== prev)) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_change at cycle %0d: outputs %h, none expected", cyc, cur);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_vec", {10'd0, cur}, {10'd0, e.vec});
        check("out_cycle", cyc, e.cyc);
      end
    end
    prev = cur;
  end

  initial begin
    int unsigned b;
    reset_n       = 1'b0;
    locked        = 1'b1;
    lock_lost_clr = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state", {10'd0, out_vec}, 32'd0);
    armed = 1'b1;

    // Clean power-up with lock present.
    b = cyc;
    reset_n = 1'b1;
    push(b + 4,  v(1'b1, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0));
    push(b + 14, v(1'b1, 3'b001, 1'b0, 1'b0, 8'd0, 8'd0));
    push(b + 16, v(1'b1, 3'b011, 1'b0, 1'b0, 8'd0, 8'd0));
    push(b + 18, v(1'b1, 3'b111, 1'b1, 1'b0, 8'd0, 8'd0));
    wait_until(b + 22);
    drained("powerup_pending");

    // Two-cycle dropout in RUN is filtered out.
    b = cyc;
    locked = 1'b0;
    wait_until(b + 2);
    locked = 1'b1;
    wait_until(b + 10);
    drained("filter_pending");

    // Three-cycle dropout is a loss event followed by a full re-sequence.
    b = cyc;
    push(b + 5,  v(1'b0, 3'b000, 1'b0, 1'b1, 8'd1, 8'd0));
    push(b + 9,  v(1'b1, 3'b000, 1'b0, 1'b1, 8'd1, 8'd0));
    push(b + 19, v(1'b1, 3'b001, 1'b0, 1'b1, 8'd1, 8'd0));
    push(b + 21, v(1'b1, 3'b011, 1'b0, 1'b1, 8'd1, 8'd0));
    push(b + 23, v(1'b1, 3'b111, 1'b1, 1'b1, 8'd1, 8'd0));
    locked = 1'b0;
    wait_until(b + 3);
    locked = 1'b1;
    wait_until(b + 26);
    drained("loss_pending");

    // Clear the sticky flag, then a loss coinciding with a clear keeps it set.
    b = cyc;
    push(b + 1, v(1'b1, 3'b111, 1'b1, 1'b0, 8'd1, 8'd0));
    lock_lost_clr = 1'b1;
    wait_until(b + 1);
    lock_lost_clr = 1'b0;
    wait_until(b + 4);
    b = cyc;
    push(b + 5,  v(1'b0, 3'b000, 1'b0, 1'b1, 8'd2, 8'd0));
    push(b + 9,  v(1'b1, 3'b000, 1'b0, 1'b1, 8'd2, 8'd0));
    push(b + 19, v(1'b1, 3'b001, 1'b0, 1'b1, 8'd2, 8'd0));
    push(b + 21, v(1'b1, 3'b011, 1'b0, 1'b1, 8'd2, 8'd0));
    push(b + 23, v(1'b1, 3'b111, 1'b1, 1'b1, 8'd2, 8'd0));
    locked = 1'b0;
    wait_until(b + 3);
    locked = 1'b1;
    wait_until(b + 4);
    lock_lost_clr = 1'b1;
    wait_until(b + 5);
    lock_lost_clr = 1'b0;
    wait_until(b + 26);
    drained("clear_race_pending");

    // Reset while in RUN.
    b = cyc;
    push(b + 1, v(1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0));
    reset_n = 1'b0;
    wait_until(b + 3);
    drained("midrun_reset_pending");

    // One-cycle lock glitch inside STABILIZE delays release by five cycles.
    b = cyc;
    reset_n = 1'b1;
    push(b + 4,  v(1'b1, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0));
    push(b + 19, v(1'b1, 3'b001, 1'b0, 1'b0, 8'd0, 8'd0));
    push(b + 21, v(1'b1, 3'b011, 1'b0, 1'b0, 8'd0, 8'd0));
    push(b + 23, v(1'b1, 3'b111, 1'b1, 1'b0, 8'd0, 8'd0));
    wait_until(b + 6);
    locked = 1'b0;
    wait_until(b + 7);
    locked = 1'b1;
    wait_until(b + 26);
    drained("glitch_pending");

    // Lock lost during RELEASE, then lock never returns: retry loop to saturation.
    b = cyc;
    push(b + 1, v(1'b0, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0));
    reset_n = 1'b0;
    wait_until(b + 3);
    b = cyc;
    reset_n = 1'b1;
    push(b + 4,  v(1'b1, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0));
    push(b + 14, v(1'b1, 3'b001, 1'b0, 1'b0, 8'd0, 8'd0));
    push(b + 15, v(1'b1, 3'b000, 1'b0, 1'b0, 8'd0, 8'd0));
    for (int n = 1; n <= 257; n++) begin
      int unsigned t;
      logic [7:0]  r;
      t = b + 47 + 36 * (n - 1);
      r = (n > 255) ? 8'd255 : 8'(n);
      push(t,     v(1'b0, 3'b000, 1'b0, 1'b0, 8'd0, r));
      push(t + 4, v(1'b1, 3'b000, 1'b0, 1'b0, 8'd0, r));
    end
    wait_until(b + 12);
    locked = 1'b0;
    wait_until(b + 9275);
    drained("retry_pending");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
